// File: rtl/aoi_sweep_checker.sv
// aoi_sweep_checker
//   Exhaustive-sweep stimulus generator and self-checker for a combinational
//   AND-OR-INVERT gate. It drives every input combination, holds each one for
//   HOLD cycles and, on the last held cycle, compares the gate's per-group AND
//   outputs and its final AOI output against a built-in golden model. It
//   reports pass/fail, a saturating error count and the first failing pattern.
//
// Ports
//   clk            in   rising-edge clock
//   rst_n          in   async active-low reset
//   start          in   one-cycle sweep request (honoured in IDLE/DONE only)
//   stim           out  gate inputs; group k = stim[k*GRP_W +: GRP_W]
//   dut_and        in   gate per-group AND outputs (bit k = group k)
//   dut_aoi        in   gate final output ~(|group ANDs)
//   busy           out  sweep in progress
//   done           out  sweep complete, held until next start
//   pass           out  valid with done: no mismatching pattern
//   err_cnt        out  mismatching patterns, saturating
//   first_fail     out  stim value of the first mismatching pattern
//   first_fail_vld out  first_fail holds a captured value
//
// State | meaning
// IDLE  | after reset, waiting for start
// RUN   | sweeping patterns, comparing on the last held cycle of each
// DONE  | sweep finished, results held until the next start

module aoi_sweep_checker #(
  parameter int NUM_GRP    = 2,
  parameter int GRP_W      = 2,
  parameter int HOLD       = 4,
  parameter int SWEEP_MODE = 0,
  parameter int ERR_W      = 8,
  localparam int N_IN      = NUM_GRP * GRP_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic [N_IN-1:0]    stim,
  input  logic [NUM_GRP-1:0] dut_and,
  input  logic               dut_aoi,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [ERR_W-1:0]   err_cnt,
  output logic [N_IN-1:0]    first_fail,
  output logic               first_fail_vld
);

  localparam int               HC_W     = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [HC_W-1:0]  HC_LAST  = HC_W'(HOLD - 1);
  localparam logic [HC_W-1:0]  HC_ONE   = HC_W'(1);
  localparam logic [N_IN-1:0]  CNT_LAST = '1;
  localparam logic [N_IN-1:0]  CNT_ONE  = N_IN'(1);
  localparam logic [ERR_W-1:0] ERR_MAX  = '1;
  localparam logic [ERR_W-1:0] ERR_ONE  = ERR_W'(1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state_q, state_d;

  logic [N_IN-1:0]    cnt_q, cnt_d;
  logic [HC_W-1:0]    hold_q, hold_d;
  logic [N_IN-1:0]    stim_d;
  logic               busy_d, done_d, pass_d, ffv_d;
  logic [ERR_W-1:0]   err_d;
  logic [N_IN-1:0]    ff_d;

  logic [NUM_GRP-1:0] exp_and;
  logic               exp_aoi;
  logic               mismatch;
  logic               cmp_edge;
  logic               last_pat;
  logic [ERR_W-1:0]   err_after;

  function automatic logic [N_IN-1:0] sweep_code(input logic [N_IN-1:0] c);
    return (SWEEP_MODE == 1) ? (c ^ (c >> 1)) : c;
  endfunction

  // Golden model works on the registered stim, which is exactly what the gate sees.
  for (genvar g = 0; g < NUM_GRP; g++) begin : g_exp
    assign exp_and[g] = &stim[g*GRP_W +: GRP_W];
  end
  assign exp_aoi  = ~|exp_and;
  assign mismatch = (dut_and != exp_and) | (dut_aoi != exp_aoi);

  assign cmp_edge = (state_q == RUN) && (hold_q == HC_LAST);
  assign last_pat = (cnt_q == CNT_LAST);

  // Count after this compare; pass on the final pattern must include it.
  always_comb begin
    err_after = err_cnt;
    if (cmp_edge && mismatch && (err_cnt != ERR_MAX))
      err_after = err_cnt + ERR_ONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (start) state_d = RUN;
      RUN:        if (cmp_edge && last_pat) state_d = DONE;
      default:    state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d  = cnt_q;
    hold_d = hold_q;
    stim_d = stim;
    busy_d = busy;
    done_d = done;
    pass_d = pass;
    err_d  = err_cnt;
    ff_d   = first_fail;
    ffv_d  = first_fail_vld;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          cnt_d  = '0;
          hold_d = '0;
          stim_d = sweep_code('0);
          busy_d = 1'b1;
          done_d = 1'b0;
          pass_d = 1'b0;
          err_d  = '0;
          ff_d   = '0;
          ffv_d  = 1'b0;
        end
      end
      RUN: begin
        hold_d = hold_q + HC_ONE;
        if (cmp_edge) begin
          err_d = err_after;
          if (mismatch && !first_fail_vld) begin
            ff_d  = stim;
            ffv_d = 1'b1;
          end
          hold_d = '0;
          if (last_pat) begin
            busy_d = 1'b0;
            done_d = 1'b1;
            pass_d = (err_after == '0);
            stim_d = '0;
          end else begin
            cnt_d  = cnt_q + CNT_ONE;
            stim_d = sweep_code(cnt_q + CNT_ONE);
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q          <= '0;
      hold_q         <= '0;
      stim           <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_cnt        <= '0;
      first_fail     <= '0;
      first_fail_vld <= 1'b0;
    end else begin
      cnt_q          <= cnt_d;
      hold_q         <= hold_d;
      stim           <= stim_d;
      busy           <= busy_d;
      done           <= done_d;
      pass           <= pass_d;
      err_cnt        <= err_d;
      first_fail     <= ff_d;
      first_fail_vld <= ffv_d;
    end
  end

endmodule

// File: tb/tb_aoi_sweep_checker.sv
module tb_aoi_sweep_checker;

  localparam int  NUM_GRP = 2;
  localparam int  GRP_W   = 2;
  localparam int  HOLD    = 4;
  localparam int  N_IN    = NUM_GRP * GRP_W;
  localparam int  NPAT    = 1 << N_IN;
  localparam int  ERR_W_A = 8;
  localparam int  ERR_W_B = 2;
  localparam time PERIOD  = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic start = 1'b0;

  logic [N_IN-1:0]    stim_a, stim_b, ff_a, ff_b;
  logic [NUM_GRP-1:0] and_a, and_b;
  logic               aoi_a, aoi_b;
  logic               busy_a, done_a, pass_a, ffv_a;
  logic               busy_b, done_b, pass_b, ffv_b;
  logic [ERR_W_A-1:0] err_a;
  logic [ERR_W_B-1:0] err_b;

  always #(PERIOD/2) clk = ~clk;

  aoi_sweep_checker #(.NUM_GRP(NUM_GRP), .GRP_W(GRP_W), .HOLD(HOLD),
                      .SWEEP_MODE(0), .ERR_W(ERR_W_A)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .stim(stim_a),
    .dut_and(and_a), .dut_aoi(aoi_a), .busy(busy_a), .done(done_a),
    .pass(pass_a), .err_cnt(err_a), .first_fail(ff_a), .first_fail_vld(ffv_a));

  aoi_sweep_checker #(.NUM_GRP(NUM_GRP), .GRP_W(GRP_W), .HOLD(HOLD),
                      .SWEEP_MODE(1), .ERR_W(ERR_W_B)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .stim(stim_b),
    .dut_and(and_b), .dut_aoi(aoi_b), .busy(busy_b), .done(done_b),
    .pass(pass_b), .err_cnt(err_b), .first_fail(ff_b), .first_fail_vld(ffv_b));

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- gate-under-test emulation ----------------
  int                 fault_mode = 0;   // 0 good, 1 aoi stuck 0, 2 and[0] inverted, 3 random table
  logic [NUM_GRP-1:0] flip_and [NPAT];
  logic               flip_aoi [NPAT];
  logic [NUM_GRP:0]   noise = '0;
  logic [N_IN-1:0]    stim_a_q = '0, stim_b_q = '0;

  function automatic logic [NUM_GRP:0] golden(input logic [N_IN-1:0] p);
    logic [NUM_GRP-1:0] a;
    for (int g = 0; g < NUM_GRP; g++)
      a[g] = (p[g*GRP_W +: GRP_W] == {GRP_W{1'b1}});
    return {(a == '0), a};
  endfunction

  function automatic logic [NUM_GRP:0] faulty(input logic [N_IN-1:0] p, input int mode);
    logic [NUM_GRP:0] r;
    r = golden(p);
    case (mode)
      1: r[NUM_GRP] = 1'b0;
      2: r[0] = ~r[0];
      3: r = r ^ {flip_aoi[p], flip_and[p]};
      default: ;
    endcase
    return r;
  endfunction

  // Noise only on the first cycle of each pattern; with HOLD>1 that is never a compare cycle.
  always @(posedge clk) begin
    noise    <= NUM_GRP'($urandom) == '0 ? (NUM_GRP+1)'(1) : (NUM_GRP+1)'($urandom);
    stim_a_q <= stim_a;
    stim_b_q <= stim_b;
  end

  always_comb begin
    {aoi_a, and_a} = faulty(stim_a, fault_mode);
    if (stim_a != stim_a_q) {aoi_a, and_a} = {aoi_a, and_a} ^ noise;
    {aoi_b, and_b} = faulty(stim_b, fault_mode);
    if (stim_b != stim_b_q) {aoi_b, and_b} = {aoi_b, and_b} ^ noise;
  end

  // ---------------- reference model ----------------
  typedef struct {
    int              err;
    logic            pass;
    logic [N_IN-1:0] ff;
    logic            ffv;
    time             t0;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];

  function automatic logic [N_IN-1:0] order(input int k, input bit gray);
    logic [N_IN-1:0] v;
    v = k[N_IN-1:0];
    return gray ? (v ^ (v >> 1)) : v;
  endfunction

  function automatic exp_t model(input int mode, input int err_w, input bit gray, input time t0);
    exp_t e;
    int   n = 0;
    int   sat = (1 << err_w) - 1;
    logic [N_IN-1:0] p;
    e.ff  = '0;
    e.ffv = 1'b0;
    for (int v = 0; v < NPAT; v++) begin
      p = order(v, gray);
      if (faulty(p, mode) != golden(p)) begin
        n++;
        if (!e.ffv) begin
          e.ff  = p;
          e.ffv = 1'b1;
        end
      end
    end
    e.err  = (n > sat) ? sat : n;
    e.pass = (n == 0);
    e.t0   = t0;
    return e;
  endfunction

  // ---------------- monitors ----------------
  time  t_start  = 0;
  bit   sweep_on = 1'b0;
  logic done_a_q = 1'b0, done_b_q = 1'b0;
  exp_t ea, eb;

  // Stim sequence and busy window, derived from elapsed time since the start edge.
  always @(negedge clk) begin
    longint el;
    bit     exp_busy;
    el       = (t_start + PERIOD/2 <= $time) ? longint'(($time - t_start - PERIOD/2) / PERIOD) : 0;
    exp_busy = sweep_on && (el < HOLD*NPAT);
    check("a_busy", busy_a, exp_busy);
    check("b_busy", busy_b, exp_busy);
    check("a_stim", stim_a, exp_busy ? order(int'(el) / HOLD, 1'b0) : '0);
    check("b_stim", stim_b, exp_busy ? order(int'(el) / HOLD, 1'b1) : '0);
  end

  always @(negedge clk) begin
    if (done_a && !done_a_q) begin
      if (q_a.size() == 0) check("a_unexpected_done", 1, 0);
      else begin
        ea = q_a.pop_front();
        check("a_latency", ($time - ea.t0 - PERIOD/2) / PERIOD, HOLD*NPAT);
        check("a_err_cnt", err_a, ea.err);
        check("a_pass", pass_a, ea.pass);
        check("a_first_fail", ff_a, ea.ff);
        check("a_first_fail_vld", ffv_a, ea.ffv);
      end
    end
    done_a_q = done_a;
  end

  always @(negedge clk) begin
    if (done_b && !done_b_q) begin
      if (q_b.size() == 0) check("b_unexpected_done", 1, 0);
      else begin
        eb = q_b.pop_front();
        check("b_latency", ($time - eb.t0 - PERIOD/2) / PERIOD, HOLD*NPAT);
        check("b_err_cnt", err_b, eb.err);
        check("b_pass", pass_b, eb.pass);
        check("b_first_fail", ff_b, eb.ff);
        check("b_first_fail_vld", ffv_b, eb.ffv);
      end
    end
    done_b_q = done_b;
  end

  // ---------------- stimulus ----------------
  task automatic pulse_start(input bit expect_new);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    if (expect_new) begin
      t_start  = $time;
      sweep_on = 1'b1;
      q_a.push_back(model(fault_mode, ERR_W_A, 1'b0, $time));
      q_b.push_back(model(fault_mode, ERR_W_B, 1'b1, $time));
    end
    @(negedge clk);
    start = 1'b0;
    if (expect_new) begin
      check("start_clears_done", done_a | done_b, 0);
      check("start_clears_err", err_a | err_b, 0);
      check("start_clears_ffv", ffv_a | ffv_b, 0);
    end
  endtask

  task automatic wait_done();
    int k = 0;
    logic [ERR_W_A-1:0] err_hold;
    logic [N_IN-1:0]    ff_hold;
    while (!(done_a && done_b) && k < 3*HOLD*NPAT) begin
      @(negedge clk);
      k++;
    end
    check("wait_done", done_a && done_b, 1);
    err_hold = err_a;
    ff_hold  = ff_b;
    repeat (7) @(negedge clk);
    check("done_held", done_a && done_b, 1);
    check("err_stable", err_a, err_hold);
    check("ff_stable", ff_b, ff_hold);
  endtask

  task automatic randomize_faults();
    for (int v = 0; v < NPAT; v++) begin
      flip_and[v] = ($urandom_range(0, 2) == 0) ? NUM_GRP'($urandom) : '0;
      flip_aoi[v] = ($urandom_range(0, 3) == 0);
    end
  endtask

  initial begin
    for (int v = 0; v < NPAT; v++) begin
      flip_and[v] = '0;
      flip_aoi[v] = 1'b0;
    end
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_outputs", {busy_a, done_a, pass_a, err_a, ff_a, ffv_a, stim_a}, 0);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("no_start_busy", busy_a | busy_b, 0);
    check("no_start_done", done_a | done_b, 0);

    fault_mode = 0;
    pulse_start(1'b1);
    wait_done();

    fault_mode = 1;
    pulse_start(1'b1);
    wait_done();

    fault_mode = 2;
    pulse_start(1'b1);
    wait_done();

    fault_mode = 3;
    for (int r = 0; r < 3; r++) begin
      randomize_faults();
      pulse_start(1'b1);
      if (r == 1) begin
        repeat (18) @(negedge clk);
        pulse_start(1'b0);
      end
      wait_done();
    end

    // Reset in the middle of a sweep: outputs clear asynchronously, no done follows.
    randomize_faults();
    pulse_start(1'b1);
    repeat (30) @(negedge clk);
    #2;
    rst_n    = 1'b0;
    sweep_on = 1'b0;
    #1;
    check("async_rst_a", {busy_a, done_a, pass_a, err_a, ff_a, ffv_a, stim_a}, 0);
    check("async_rst_b", {busy_b, done_b, pass_b, err_b, ff_b, ffv_b, stim_b}, 0);
    q_a.delete();
    q_b.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (HOLD*NPAT + 10) @(negedge clk);
    check("no_done_after_rst", done_a | done_b, 0);

    fault_mode = 0;
    pulse_start(1'b1);
    wait_done();

    repeat (3) @(negedge clk);
    check("queue_drain", q_a.size() + q_b.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
